// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the HUD score keeper.
// Point values, saturation limit, game mode and BCD word types.
package score_keeper_pkg;

    typedef enum logic [1:0] {
        GAME_MODE_LOADING,
        GAME_MODE_READY,
        GAME_MODE_PLAYING,
        GAME_MODE_OVER
    } game_mode_t;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_S,
        CONV_H,
        CONV_PUBLISH
    } conv_state_t;

    localparam int unsigned PTS_PELLET     = 10;
    localparam int unsigned PTS_POWER      = 50;
    localparam int unsigned PTS_GHOST_BASE = 200;
    localparam int unsigned MAX_SCORE      = 9999;

    typedef logic [3:0][3:0] bcd4_t;

endpackage

// File: rtl/score_keeper_if.sv
// Game-side bundle for the score keeper: mode, events, scores.
// master drives events, slave is the score keeper itself.
interface score_keeper_if;
    import score_keeper_pkg::*;

    game_mode_t  MODE;
    logic        frame_start;
    logic        ev_pellet;
    logic        ev_power;
    logic        ev_ghost;
    logic [15:0] score;
    logic [15:0] high_score;
    bcd4_t       score_bcd;
    bcd4_t       high_bcd;
    logic        bcd_valid;

    modport master (
        output MODE, frame_start, ev_pellet, ev_power, ev_ghost,
        input  score, high_score, score_bcd, high_bcd, bcd_valid
    );

    modport slave (
        input  MODE, frame_start, ev_pellet, ev_power, ev_ghost,
        output score, high_score, score_bcd, high_bcd, bcd_valid
    );

endinterface

// File: rtl/score_keeper_bcd_serial.sv
// Serial double-dabble: one bit per cycle, add-3 then shift.
// start loads the operand; done pulses once the last bit is in.
module bcd_serial #(
    parameter int BIN_WIDTH  = 16,
    parameter int BCD_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    binary,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int CW = $clog2(BIN_WIDTH + 1);

    logic [BIN_WIDTH-1:0]    sr;
    logic [4*BCD_DIGITS-1:0] adj;
    logic [CW-1:0]           cnt;

    // Add 3 to every digit that will overflow past 9 on the shift.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Load on start when idle, otherwise shift one bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    sr   <= binary;
                    bcd  <= '0;
                    cnt  <= CW'(BIN_WIDTH);
                    busy <= 1'b1;
                end
            end else begin
                {bcd, sr} <= {adj, sr} << 1;
                cnt       <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Running score, high score and frame-synchronous BCD publishing.
// Both snapshots convert back to back and publish in one edge.
module score_keeper
    import score_keeper_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    score_keeper_if.slave bus
);

    game_mode_t  prev_mode;
    logic [1:0]  combo;
    logic        allow;
    logic        enter_ready;
    logic [16:0] ghost_pts;
    logic [16:0] inc;
    logic [16:0] sum;
    logic [15:0] next_score;

    conv_state_t state;
    logic        pending;
    logic [15:0] snap_h;
    logic [15:0] conv_bin;
    logic        conv_start;
    logic        conv_busy;
    logic        conv_done;
    bcd4_t       conv_bcd;
    bcd4_t       res_s;

    // Next score: clear on entry to READY, saturating add while playing.
    always_comb begin
        allow = !(bus.MODE == GAME_MODE_LOADING ||
                  bus.MODE == GAME_MODE_READY);
        enter_ready = (bus.MODE == GAME_MODE_READY) &&
                      (prev_mode != GAME_MODE_READY);
        ghost_pts = 17'(PTS_GHOST_BASE) << combo;
        inc = (bus.ev_pellet ? 17'(PTS_PELLET) : 17'd0)
            + (bus.ev_power  ? 17'(PTS_POWER)  : 17'd0)
            + (bus.ev_ghost  ? ghost_pts       : 17'd0);
        sum = {1'b0, bus.score} + inc;
        next_score = bus.score;
        if (enter_ready)
            next_score = '0;
        else if (allow)
            next_score = (sum > 17'(MAX_SCORE)) ?
                         16'(MAX_SCORE) : sum[15:0];
    end

    // Score, high score and ghost combo registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_mode      <= GAME_MODE_LOADING;
            combo          <= '0;
            bus.score      <= '0;
            bus.high_score <= '0;
        end else begin
            prev_mode <= bus.MODE;
            bus.score <= next_score;
            if (next_score > bus.high_score)
                bus.high_score <= next_score;
            if (allow) begin
                if (bus.ev_power)
                    combo <= '0;
                else if (bus.ev_ghost && combo != 2'd3)
                    combo <= combo + 2'd1;
            end
        end
    end

    bcd_serial #(
        .BIN_WIDTH  (16),
        .BCD_DIGITS (4)
    ) u_bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (conv_start),
        .binary (conv_bin),
        .busy   (conv_busy),
        .done   (conv_done),
        .bcd    (conv_bcd)
    );

    // Conversion sequencer: snapshot, convert score, convert high, publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CONV_IDLE;
            pending       <= 1'b0;
            snap_h        <= '0;
            conv_bin      <= '0;
            conv_start    <= 1'b0;
            res_s         <= '0;
            bus.score_bcd <= '0;
            bus.high_bcd  <= '0;
            bus.bcd_valid <= 1'b0;
        end else begin
            conv_start    <= 1'b0;
            bus.bcd_valid <= 1'b0;
            unique case (state)
                CONV_IDLE: begin
                    if ((bus.frame_start || pending) && !conv_busy) begin
                        snap_h     <= bus.high_score;
                        conv_bin   <= bus.score;
                        pending    <= 1'b0;
                        conv_start <= 1'b1;
                        state      <= CONV_S;
                    end
                end
                CONV_S: begin
                    if (bus.frame_start)
                        pending <= 1'b1;
                    if (conv_done) begin
                        res_s      <= conv_bcd;
                        conv_bin   <= snap_h;
                        conv_start <= 1'b1;
                        state      <= CONV_H;
                    end
                end
                CONV_H: begin
                    if (bus.frame_start)
                        pending <= 1'b1;
                    if (conv_done) begin
                        bus.score_bcd <= res_s;
                        bus.high_bcd  <= conv_bcd;
                        bus.bcd_valid <= 1'b1;
                        state         <= CONV_PUBLISH;
                    end
                end
                CONV_PUBLISH: begin
                    if (bus.frame_start)
                        pending <= 1'b1;
                    state <= CONV_IDLE;
                end
                default: state <= CONV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: directed events, BCD publishes
// checked by a monitor against queued hand-computed values.
module tb_score_keeper;
    import score_keeper_pkg::*;

    typedef struct {
        logic [15:0] s;
        logic [15:0] h;
        int          start;
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t q[$];

    score_keeper_if sk();

    score_keeper dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sk.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One event cycle, then one idle cycle.
    task automatic ev(input bit p, input bit w, input bit g,
                      input bit fs, input bit push,
                      input logic [15:0] es, input logic [15:0] eh,
                      input bit lat);
        exp_t e;
        @(negedge clk);
        sk.ev_pellet   = p;
        sk.ev_power    = w;
        sk.ev_ghost    = g;
        sk.frame_start = fs;
        if (fs && push) begin
            e.s = es;
            e.h = eh;
            e.start = cyc + 1;
            e.chk_lat = lat;
            q.push_back(e);
        end
        @(negedge clk);
        sk.ev_pellet   = 1'b0;
        sk.ev_power    = 1'b0;
        sk.ev_ghost    = 1'b0;
        sk.frame_start = 1'b0;
    endtask

    task automatic pellet();
        ev(1, 0, 0, 0, 0, 16'h0, 16'h0, 0);
    endtask

    task automatic power();
        ev(0, 1, 0, 0, 0, 16'h0, 16'h0, 0);
    endtask

    task automatic ghost();
        ev(0, 0, 1, 0, 0, 16'h0, 16'h0, 0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every publish pops one expectation.
    always @(negedge clk) begin
        if (rst_n && sk.bcd_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("score_bcd", sk.score_bcd, e.s);
                check("high_bcd", sk.high_bcd, e.h);
                if (e.chk_lat)
                    check("latency", cyc - e.start, 36);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        sk.MODE        = GAME_MODE_LOADING;
        sk.frame_start = 1'b0;
        sk.ev_pellet   = 1'b0;
        sk.ev_power    = 1'b0;
        sk.ev_ghost    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_score", sk.score, 0);
        check("rst_high", sk.high_score, 0);
        check("rst_sbcd", sk.score_bcd, 0);
        check("rst_hbcd", sk.high_bcd, 0);
        check("rst_valid", sk.bcd_valid, 0);
        rst_n = 1'b1;

        pellet();
        check("loading_ignore", sk.score, 0);

        sk.MODE = GAME_MODE_PLAYING;
        repeat (3) pellet();
        check("pellets", sk.score, 30);
        ev(0, 0, 0, 1, 1, 16'h0030, 16'h0030, 1);
        drain("drain_30");

        power();
        repeat (5) ghost();
        check("ghost_chain", sk.score, 4680);
        check("ghost_high", sk.high_score, 4680);

        power();
        ghost();
        ghost();
        check("combo2", sk.score, 5330);
        ev(1, 1, 1, 0, 0, 16'h0, 16'h0, 0);
        check("same_cycle", sk.score, 6190);
        ghost();
        check("combo_reset", sk.score, 6390);
        ev(0, 0, 0, 1, 1, 16'h6390, 16'h6390, 1);
        drain("drain_6390");

        repeat (3) ghost();
        power();
        ghost();
        ghost();
        repeat (15) pellet();
        check("pre_sat", sk.score, 9990);
        power();
        check("sat", sk.score, 9999);
        ghost();
        check("sat_hold", sk.score, 9999);
        check("sat_high", sk.high_score, 9999);
        ev(0, 0, 0, 1, 1, 16'h9999, 16'h9999, 1);
        drain("drain_9999");

        do_reset();
        check("rst2_score", sk.score, 0);
        check("rst2_high", sk.high_score, 0);
        check("rst2_sbcd", sk.score_bcd, 0);

        power();
        ghost();
        ghost();
        power();
        ghost();
        ghost();
        check("build_1300", sk.score, 1300);

        @(negedge clk);
        sk.MODE = GAME_MODE_READY;
        @(negedge clk);
        check("ready_clear", sk.score, 0);
        check("ready_high", sk.high_score, 1300);
        pellet();
        ghost();
        check("ready_ignore", sk.score, 0);
        sk.MODE = GAME_MODE_PLAYING;
        pellet();
        check("play_again", sk.score, 10);
        check("high_kept", sk.high_score, 1300);

        ev(0, 0, 0, 1, 1, 16'h0010, 16'h1300, 1);
        pellet();
        pellet();
        ev(0, 0, 0, 1, 1, 16'h0030, 16'h1300, 0);
        ev(0, 0, 0, 1, 0, 16'h0, 16'h0, 0);
        drain("drain_pending");
        repeat (60) @(negedge clk);

        ev(0, 0, 0, 1, 0, 16'h0, 16'h0, 0);
        repeat (22) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_score", sk.score, 0);
        check("abort_high", sk.high_score, 0);
        check("abort_sbcd", sk.score_bcd, 0);
        check("abort_hbcd", sk.high_bcd, 0);
        check("abort_valid", sk.bcd_valid, 0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("final_queue", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
